// File: rtl/regfile_dump_reader.sv
// Walks a 2-read-port register file pair by pair and streams every register
// out as (index, data) words over a valid/ready interface.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rdReg1,
   input  logic [DATA_W-1:0] rdData1,
   output logic [ADDR_W-1:0] rdReg2,
   input  logic [DATA_W-1:0] rdData2,
   output logic              outValid,
   input  logic              outReady,
   output logic [ADDR_W-1:0] outReg,
   output logic [DATA_W-1:0] outData,
   output logic              outLast
);

   // state  | meaning
   // IDLE   | waiting for start, read ports parked on pair (0,1)
   // READ   | read ports on (idx, idx+1); both words snapshotted on this edge
   // SEND_A | offering word idx (even register)
   // SEND_B | offering word idx+1 (odd register)
   // DONE   | one-cycle done pulse, then back to IDLE
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SEND_A,
      S_SEND_B,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_TWO  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]   hold_b_q, hold_b_d;
   logic [ADDR_W-1:0]   out_reg_q, out_reg_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic [ADDR_W-1:0]   rd_reg1_q, rd_reg1_d;
   logic [ADDR_W-1:0]   rd_reg2_q, rd_reg2_d;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         hold_b_q   <= '0;
         out_reg_q  <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         rd_reg1_q  <= '0;
         rd_reg2_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hold_b_q   <= hold_b_d;
         out_reg_q  <= out_reg_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         rd_reg1_q  <= rd_reg1_d;
         rd_reg2_q  <= rd_reg2_d;
      end
   end

   // The even word goes straight into the output register, so it doubles as
   // the first holding register; only the odd word needs its own.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_b_d   = hold_b_q;
      out_reg_d  = out_reg_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            hold_b_d   = rdData2;
            out_reg_d  = idx_q;
            out_data_d = rdData1;
            out_last_d = 1'b0;
            state_d    = S_SEND_A;
         end
         S_SEND_A: begin
            if (outReady) begin
               out_reg_d  = idx_q + IDX_ONE;
               out_data_d = hold_b_q;
               out_last_d = ((idx_q + IDX_ONE) == LAST_IDX);
               state_d    = S_SEND_B;
            end
         end
         S_SEND_B: begin
            if (outReady) begin
               if (out_last_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_TWO;
                  state_d = S_READ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort wins over an acceptance on the same edge.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   // Read ports track the next pair so they are already settled in READ.
   always_comb begin
      if (state_d == S_IDLE) begin
         rd_reg1_d = '0;
         rd_reg2_d = IDX_ONE;
      end else begin
         rd_reg1_d = idx_d;
         rd_reg2_d = idx_d + IDX_ONE;
      end
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      outValid = 1'b0;
      case (state_q)
         S_IDLE:   busy = 1'b0;
         S_READ:   busy = 1'b1;
         S_SEND_A: begin
            busy     = 1'b1;
            outValid = 1'b1;
         end
         S_SEND_B: begin
            busy     = 1'b1;
            outValid = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign rdReg1  = rd_reg1_q;
   assign rdReg2  = rd_reg2_q;
   assign outReg  = out_reg_q;
   assign outData = out_data_q;
   assign outLast = out_last_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader for the 2-read-port, 32x32 register file: on a start pulse it walks every register pair through the two combinational read ports (rdReg1/rdData1, rdReg2/rdData2).
- Streams each register out as (index, data) over a valid/ready interface.
- Used for debug register dumps and self-check benches; the datapath's writer uses the write port independently.

Parameters:
- NUM_REGS, 32, registers dumped; must be even and >= 2.
- ADDR_W, 5, register index width; 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  begin dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE without done.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last register is accepted.
- rdReg1  out  ADDR_W  read-port-1 index (even index of current pair).
- rdData1  in  DATA_W  read-port-1 data (combinational from the register file).
- rdReg2  out  ADDR_W  read-port-2 index (odd index of current pair).
- rdData2  in  DATA_W  read-port-2 data.
- outValid  out  1  stream word valid.
- outReady  in  1  sink accepts the word when outValid && outReady at posedge.
- outReg  out  ADDR_W  register index of the stream word.
- outData  out  DATA_W  register contents.
- outLast  out  1  high with the word for index NUM_REGS-1.

Behaviour:
- Clock is clk; reset is resetN, asynchronous, active-low.
- Reset values: state=IDLE, idx=0, busy=0, done=0, outValid=0, outLast=0, outReg=0, outData=0, rdReg1=0, rdReg2=0, holding registers=0.
- Reset asserted mid-dump: immediate return to IDLE with the above values; no done.
- State IDLE: rdReg1=0, rdReg2=1.
  - start=1 at posedge: idx<=0, go to READ.
  - start is ignored in every other state.
- State READ (one cycle): rdReg1=idx, rdReg2=idx+1.
  - At posedge, capture rdData1->holdA and rdData2->holdB; go to SEND_A.
  - The pair is atomic (same-edge snapshot). A write to either register in the READ cycle is not visible. Writes between pairs are visible.
- State SEND_A: outValid=1, outReg=idx, outData=holdA, outLast=0.
  - Accepted: go to SEND_B.
- State SEND_B: outValid=1, outReg=idx+1, outData=holdB, outLast=(idx+1==NUM_REGS-1).
  - Accepted with outLast: go to DONE.
  - Accepted otherwise: idx<=idx+2, go to READ.
- State DONE (one cycle): done=1, outValid=0; then go to IDLE.
- Handshake rules:
  - While outValid && !outReady, outReg, outData and outLast stay stable.
  - outValid never drops without acceptance, except on abort or reset.
  - outValid does not depend combinationally on outReady.
- abort=1 at any posedge while busy: go to IDLE, outValid<=0, no done. Abort has priority over acceptance in the same cycle.
- Index arithmetic: idx is ADDR_W bits wide and never exceeds NUM_REGS-2. idx+1 never wraps because NUM_REGS is even.
- Latency: start edge to first outValid = 2 cycles. Minimum full dump with outReady tied high = 3*(NUM_REGS/2) cycles plus 1 DONE cycle (49 cycles for 32 registers).
- busy is high from the cycle after start through the DONE cycle inclusive.
- outReg, outData and outLast hold their last values when outValid=0; consumers qualify them with outValid.

Test Plan:
- Preload reg[i]=2*i for i=0..31, outReady=1, pulse start -> 32 words in order (0,0),(1,2)...(31,62); outLast only on index 31; done pulses exactly 1 cycle after the last acceptance; 49 busy cycles.
- Same preload, outReady toggles 1,0,0,1 repeatedly -> same 32 words, each held stable through stall cycles, no duplicates or drops.
- Write reg[4]=32'hDEADBEEF during the SEND_A cycle of pair (4,5) -> word 4 still reads 8; rerun the dump -> word 4 reads DEADBEEF.
- Assert abort while in SEND_B of pair (10,11) -> outValid=0 next cycle, busy=0, no done; a new start then dumps all 32 words from index 0.
- Drop resetN asynchronously mid-clock during pair (20,21) -> all outputs 0 immediately; start pulses during busy are ignored (word count stays 32).
- NUM_REGS=4 build, reg={5,6,7,8} -> 4 words, outLast on index 3, 7 busy cycles.
